// File: rtl/verificador_except.sv
// Exception/interrupt checker for the rv32i core: decodes the current instruction,
// fetch/data addresses and mstatus/mip into one registered trap decision plus mcause.
// Latency: one cycle (inputs at edge N show on outputs after edge N); no backpressure, recomputed every cycle.
module verificador_except #(
  parameter logic [15:0] ROM_LIMIT = 16'h1000,
  parameter logic [15:0] RAM_LIMIT = 16'h1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mstatus,
  input  logic [31:0] mip,
  input  logic [15:0] addr_rom,
  input  logic [15:0] addr_ram,
  input  logic [31:0] instr,
  output logic        exception,
  output logic        interrup,
  output logic [31:0] excep_info
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  logic        exception_q, exception_d;
  logic        interrup_q,  interrup_d;
  logic [31:0] excep_info_q, excep_info_d;

  logic        legal;
  logic        is_load, is_store;
  logic        mem_misaligned;
  logic        irq_pending;
  logic [4:0]  irq_cause;

  // Opcode/funct legality table; anything not listed below is an illegal instruction.
  always_comb begin
    legal = 1'b0;
    unique case (opcode)
      OP_R:      legal = (funct7 == 7'b0000000) ||
                         ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      OP_I: begin
        if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       legal = 1'b1;
      end
      OP_LOAD:   legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      OP_STORE:  legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      OP_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      OP_JALR:   legal = (funct3 == 3'b000);
      OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
      // funct3 000 carries only ecall/ebreak/mret; 100 is unused; the rest are CSR ops.
      OP_SYSTEM: legal = (instr == INSTR_ECALL) || (instr == INSTR_EBREAK) || (instr == INSTR_MRET) ||
                         ((funct3 != 3'b000) && (funct3 != 3'b100));
      default:   legal = 1'b0;
    endcase
  end

  // Data-side checks apply only to legal loads/stores; funct3[1:0] gives the access size.
  always_comb begin
    is_load        = legal && (opcode == OP_LOAD);
    is_store       = legal && (opcode == OP_STORE);
    mem_misaligned = ((funct3[1:0] == 2'b01) && addr_ram[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_ram[1:0] != 2'b00));
  end

  // Interrupt pending and cause: MEIP over MSIP over MTIP.
  always_comb begin
    irq_pending = mstatus[3] & (mip[11] | mip[7] | mip[3]);
    if (mip[11])     irq_cause = 5'd11;
    else if (mip[3]) irq_cause = 5'd3;
    else             irq_cause = 5'd7;
  end

  // Prioritised trap decision; any exception masks the interrupt for this cycle.
  always_comb begin
    exception_d  = 1'b1;
    interrup_d   = 1'b0;
    excep_info_d = 32'd0;
    if (addr_rom >= ROM_LIMIT)                      excep_info_d = 32'd1;
    else if (addr_rom[1:0] != 2'b00)                excep_info_d = 32'd0;
    else if (!legal)                                excep_info_d = 32'd2;
    else if (instr == INSTR_EBREAK)                 excep_info_d = 32'd3;
    else if (instr == INSTR_ECALL)                  excep_info_d = 32'd11;
    else if (is_load && mem_misaligned)             excep_info_d = 32'd4;
    else if (is_store && mem_misaligned)            excep_info_d = 32'd6;
    else if (is_load && (addr_ram >= RAM_LIMIT))    excep_info_d = 32'd5;
    else if (is_store && (addr_ram >= RAM_LIMIT))   excep_info_d = 32'd7;
    else begin
      exception_d = 1'b0;
      if (irq_pending) begin
        interrup_d   = 1'b1;
        excep_info_d = {1'b1, 26'd0, irq_cause};
      end
    end
  end

  // Output register; reset clears the decision immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exception_q  <= 1'b0;
      interrup_q   <= 1'b0;
      excep_info_q <= 32'd0;
    end else begin
      exception_q  <= exception_d;
      interrup_q   <= interrup_d;
      excep_info_q <= excep_info_d;
    end
  end

  assign exception  = exception_q;
  assign interrup   = interrup_q;
  assign excep_info = excep_info_q;

endmodule

// File: tb/tb_verificador_except.sv
module tb_verificador_except;

  logic        clk;
  logic        rst_n;
  logic [31:0] mstatus;
  logic [31:0] mip;
  logic [15:0] addr_rom;
  logic [15:0] addr_ram;
  logic [31:0] instr;
  logic        exception;
  logic        interrup;
  logic [31:0] excep_info;

  int n_checks = 0;
  int n_pass   = 0;

  verificador_except dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mstatus    (mstatus),
    .mip        (mip),
    .addr_rom   (addr_rom),
    .addr_ram   (addr_ram),
    .instr      (instr),
    .exception  (exception),
    .interrup   (interrup),
    .excep_info (excep_info)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [15:0] addr_rom;
    logic [15:0] addr_ram;
    logic [31:0] mstatus;
    logic [31:0] mip;
    logic        exp_exc;
    logic        exp_int;
    logic [31:0] exp_info;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] ADDI   = 32'h0070_0293;
  localparam logic [31:0] LW     = 32'h0070_2283;
  localparam logic [31:0] LB     = 32'h0070_0283;
  localparam logic [31:0] SW     = 32'h0050_2023;
  localparam logic [31:0] SH     = 32'h0050_1023;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  function automatic vec_t mk(string name, logic [31:0] ins, logic [15:0] rom, logic [15:0] ram,
                              logic [31:0] ms, logic [31:0] ip,
                              logic ee, logic ei, logic [31:0] info);
    vec_t v;
    v.name = name; v.instr = ins; v.addr_rom = rom; v.addr_ram = ram;
    v.mstatus = ms; v.mip = ip; v.exp_exc = ee; v.exp_int = ei; v.exp_info = info;
    return v;
  endfunction

  task automatic check(string name, logic ee, logic ei, logic [31:0] info);
    n_checks++;
    if (exception === ee && interrup === ei && excep_info === info) n_pass++;
    else $display("FAIL %s: got exc=%b int=%b info=%h, expected exc=%b int=%b info=%h",
                  name, exception, interrup, excep_info, ee, ei, info);
  endtask

  task automatic apply(vec_t v);
    instr = v.instr; addr_rom = v.addr_rom; addr_ram = v.addr_ram;
    mstatus = v.mstatus; mip = v.mip;
  endtask

  initial begin
    vecs.push_back(mk("addi_ok",        ADDI,          16'h0008, 16'h0000, 32'h0, 32'h0,   1'b0, 1'b0, 32'd0));
    vecs.push_back(mk("opcode_7f",      32'h007002FF,  16'h0008, 16'h0000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd2));
    vecs.push_back(mk("lw_ram_fault",   LW,            16'h0008, 16'hF000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd5));
    vecs.push_back(mk("lw_misalign",    LW,            16'h0008, 16'h0002, 32'h0, 32'h0,   1'b1, 1'b0, 32'd4));
    vecs.push_back(mk("lb_odd_ok",      LB,            16'h0008, 16'h0003, 32'h0, 32'h0,   1'b0, 1'b0, 32'd0));
    vecs.push_back(mk("rom_fault",      ADDI,          16'hF008, 16'h0000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd1));
    vecs.push_back(mk("rom_fault_prio", 32'h007002FF,  16'hF008, 16'h0000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd1));
    vecs.push_back(mk("rom_limit_edge", ADDI,          16'h1000, 16'h0000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd1));
    vecs.push_back(mk("rom_misalign",   ADDI,          16'h0FFE, 16'h0000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd0));
    vecs.push_back(mk("irq_mtip",       ADDI,          16'h0008, 16'h0000, 32'h8, 32'h80,  1'b0, 1'b1, 32'h8000_0007));
    vecs.push_back(mk("irq_masked",     ADDI,          16'h0008, 16'h0000, 32'h1, 32'h80,  1'b0, 1'b0, 32'd0));
    vecs.push_back(mk("ecall_over_irq", ECALL,         16'h0008, 16'h0000, 32'h8, 32'h80,  1'b1, 1'b0, 32'd11));
    vecs.push_back(mk("ebreak",         EBREAK,        16'h0008, 16'h0000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd3));
    vecs.push_back(mk("mret_ok",        MRET,          16'h0008, 16'h0000, 32'h0, 32'h0,   1'b0, 1'b0, 32'd0));
    vecs.push_back(mk("irq_meip_prio",  ADDI,          16'h0008, 16'h0000, 32'h8, 32'h888, 1'b0, 1'b1, 32'h8000_000B));
    vecs.push_back(mk("irq_msip_prio",  ADDI,          16'h0008, 16'h0000, 32'h8, 32'h88,  1'b0, 1'b1, 32'h8000_0003));
    vecs.push_back(mk("all_zero",       32'h0,         16'h0008, 16'h0000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd2));
    vecs.push_back(mk("all_ones",       32'hFFFFFFFF,  16'h0008, 16'h0000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd2));
    vecs.push_back(mk("sw_ram_ok",      SW,            16'h0008, 16'h0FFC, 32'h0, 32'h0,   1'b0, 1'b0, 32'd0));
    vecs.push_back(mk("sw_ram_fault",   SW,            16'h0008, 16'h1000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd7));
    vecs.push_back(mk("sw_misalign",    SW,            16'h0008, 16'h0002, 32'h0, 32'h0,   1'b1, 1'b0, 32'd6));
    vecs.push_back(mk("sh_misalign",    SH,            16'h0008, 16'h0001, 32'h0, 32'h0,   1'b1, 1'b0, 32'd6));
    vecs.push_back(mk("sh_ok",          SH,            16'h0008, 16'h0002, 32'h0, 32'h0,   1'b0, 1'b0, 32'd0));
    vecs.push_back(mk("sub_ok",         32'h40000033,  16'h0008, 16'h0000, 32'h0, 32'h0,   1'b0, 1'b0, 32'd0));
    vecs.push_back(mk("r_bad_f7",       32'h40001033,  16'h0008, 16'h0000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd2));
    vecs.push_back(mk("add_ram_ignored",32'h00000033,  16'h0008, 16'hF001, 32'h0, 32'h0,   1'b0, 1'b0, 32'd0));
    vecs.push_back(mk("csrrs_ok",       32'h00002073,  16'h0008, 16'h0000, 32'h0, 32'h0,   1'b0, 1'b0, 32'd0));
    vecs.push_back(mk("sys_f3_100",     32'h00004073,  16'h0008, 16'h0000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd2));
    vecs.push_back(mk("srai_ok",        32'h40005013,  16'h0008, 16'h0000, 32'h0, 32'h0,   1'b0, 1'b0, 32'd0));
    vecs.push_back(mk("slli_bad_f7",    32'h40001013,  16'h0008, 16'h0000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd2));
    vecs.push_back(mk("branch_f3_010",  32'h00002063,  16'h0008, 16'h0000, 32'h0, 32'h0,   1'b1, 1'b0, 32'd2));

    rst_n = 1'b0;
    instr = ADDI; addr_rom = 16'h0008; addr_ram = 16'h0; mstatus = 32'h0; mip = 32'h0;
    #1 check("reset_state", 1'b0, 1'b0, 32'd0);
    // Drive an illegal instruction during reset: outputs must stay cleared.
    instr = 32'h007002FF;
    @(posedge clk); #1 check("held_in_reset", 1'b0, 1'b0, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("before_first_edge", 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1 check("first_edge_after_release", 1'b1, 1'b0, 32'd2);

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      @(posedge clk); #1;
      check(vecs[i].name, vecs[i].exp_exc, vecs[i].exp_int, vecs[i].exp_info);
    end

    // One-cycle latency: a new input must not appear before the next edge.
    @(negedge clk); apply(vecs[0]);
    @(posedge clk); #1 check("latency_setup", 1'b0, 1'b0, 32'd0);
    @(negedge clk); instr = 32'h007002FF;
    #1 check("latency_not_early", 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1 check("latency_one_cycle", 1'b1, 1'b0, 32'd2);

    // Mid-cycle reset while exception is high clears at once and holds until release.
    #2 rst_n = 1'b0;
    #1 check("async_reset_clear", 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1 check("reset_hold", 1'b0, 1'b0, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("release_before_edge", 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1 check("resume_after_reset", 1'b1, 1'b0, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
